rgb_color_sequencer: RTL and testbench

- Controller that schedules the RGB duty values driven into the team's 8-bit PWM generators.
- Walks a fixed 7-colour palette with programmable dwell and optional linear fades, selected by the board switches.
- Duty outputs are shadowed and only change on a PWM period boundary, so a period is never glitched mid-cycle.

---
 rtl/rgb_seq_pkg.sv | 43 ++++
 rtl/tick_prescaler.sv | 30 +++
 rtl/rgb_color_sequencer.sv | 176 +++++++++++++++++
 tb/tb_rgb_color_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb_seq_pkg.sv
// Shared definitions for the RGB colour sequencer.
//   - PAL_R/G/B : 7-entry colour palette, 8-bit per channel
//   - MODE_*    : switch encodings (static, step, fade, blank)
//   - state_e   : sequencer FSM states
//   - idx_next  : palette index successor with 6 -> 0 wrap
//   - step_toward : moves a channel one count toward its target
package rgb_seq_pkg;

    localparam int unsigned NumColors = 7;

    // Index:                           red     orange  yellow  green   blue    pinying purple
    localparam logic [7:0] PAL_R [0:6] = '{8'd255, 8'd255, 8'd255, 8'd0,   8'd0,   8'd8,   8'd160};
    localparam logic [7:0] PAL_G [0:6] = '{8'd0,   8'd97,  8'd255, 8'd255, 8'd0,   8'd46,  8'd32};
    localparam logic [7:0] PAL_B [0:6] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 8'd84,  8'd240};

    localparam logic [1:0] MODE_STATIC = 2'b00;
    localparam logic [1:0] MODE_STEP   = 2'b01;
    localparam logic [1:0] MODE_FADE   = 2'b10;
    localparam logic [1:0] MODE_BLANK  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StStatic,
        StDwell,
        StFade,
        StBlank
    } state_e;

    function automatic logic [2:0] idx_next(input logic [2:0] idx);
        return (idx == 3'(NumColors - 1)) ? 3'd0 : idx + 3'd1;
    endfunction

    // Never passes the target, so no wrap is possible.
    function automatic logic [7:0] step_toward(input logic [7:0] cur, input logic [7:0] tgt);
        if (cur < tgt) begin
            return cur + 8'd1;
        end else if (cur > tgt) begin
            return cur - 8'd1;
        end
        return cur;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running enable-gated prescaler producing a 1-cycle tick.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   en   : count enable; 0 holds the count and suppresses tick
//   tick : high for one cycle when the count sits at PRESCALE-1
module tick_prescaler #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int unsigned     CntW   = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(PRESCALE - 1);

    logic [CntW-1:0] cnt_q;

    assign tick = en && (cnt_q == CntMax);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == CntMax) ? '0 : cnt_q + CntW'(1);
        end
    end

endmodule

// File: rtl/rgb_color_sequencer.sv
// RGB colour sequencer feeding three 8-bit PWM generators.
//   clk        : clock
//   rst        : asynchronous active-low reset
//   en         : sequencer enable; 0 freezes counters, state and working colour
//   sw         : mode 00 static, 01 step, 10 fade, 11 blank
//   period_end : pulse from the PWM on the last cycle of its period
//   R/G/B_time_out : shadowed duty values, loaded only on period_end
//   color_idx  : current palette index (unshadowed)
//   upd        : 1-cycle pulse the cycle after a shadow load
module rgb_color_sequencer
    import rgb_seq_pkg::*;
#(
    parameter int unsigned PRESCALE = 50000,
    parameter int unsigned DWELL    = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] sw,
    input  logic       period_end,
    output logic [7:0] R_time_out,
    output logic [7:0] G_time_out,
    output logic [7:0] B_time_out,
    output logic [2:0] color_idx,
    output logic       upd
);

    localparam int unsigned    DwW      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DwW-1:0] DwellMax = DwW'(DWELL - 1);

    logic           tick;
    state_e         state_q;
    logic [2:0]     idx_q;
    logic [7:0]     wr_q, wg_q, wb_q;
    logic [DwW-1:0] dwell_q;
    logic [1:0]     sw_q;
    logic [7:0]     r_out_q, g_out_q, b_out_q;
    logic           upd_q;

    logic [2:0] nxt;
    logic [7:0] tgt_r, tgt_g, tgt_b;
    logic [7:0] fr, fg, fb;
    logic       fade_done;
    logic       mode_chg;
    logic       dwell_last;

    tick_prescaler #(
        .PRESCALE(PRESCALE)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .tick(tick)
    );

    always_comb begin
        nxt        = idx_next(idx_q);
        tgt_r      = PAL_R[nxt];
        tgt_g      = PAL_G[nxt];
        tgt_b      = PAL_B[nxt];
        fr         = step_toward(wr_q, tgt_r);
        fg         = step_toward(wg_q, tgt_g);
        fb         = step_toward(wb_q, tgt_b);
        // Judged on the post-step values so arrival and index advance share one tick.
        fade_done  = (fr == tgt_r) && (fg == tgt_g) && (fb == tgt_b);
        mode_chg   = (sw != sw_q);
        dwell_last = (dwell_q == DwellMax);
    end

    // Sequencer FSM; everything holds while en is low, including sw_q, so a
    // switch change made while frozen is seen as a mode change on resume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            wr_q    <= '0;
            wg_q    <= '0;
            wb_q    <= '0;
            dwell_q <= '0;
            sw_q    <= MODE_STATIC;
        end else if (en) begin
            sw_q <= sw;
            if (state_q == StIdle) begin
                // Fade mode starts with a dwell on the current colour.
                dwell_q <= '0;
                if (sw == MODE_BLANK) begin
                    state_q <= StBlank;
                end else begin
                    state_q <= (sw == MODE_STATIC) ? StStatic : StDwell;
                    wr_q    <= PAL_R[idx_q];
                    wg_q    <= PAL_G[idx_q];
                    wb_q    <= PAL_B[idx_q];
                end
            end else if (mode_chg) begin
                // Any tick in this cycle is dropped.
                dwell_q <= '0;
                unique case (sw)
                    MODE_STATIC, MODE_STEP: begin
                        state_q <= (sw == MODE_STATIC) ? StStatic : StDwell;
                        wr_q    <= PAL_R[idx_q];
                        wg_q    <= PAL_G[idx_q];
                        wb_q    <= PAL_B[idx_q];
                    end
                    MODE_FADE: state_q <= StFade;
                    default:   state_q <= StBlank;
                endcase
            end else begin
                unique case (state_q)
                    StStatic: begin
                        wr_q <= PAL_R[idx_q];
                        wg_q <= PAL_G[idx_q];
                        wb_q <= PAL_B[idx_q];
                    end
                    StDwell: begin
                        if (tick) begin
                            if (dwell_last) begin
                                dwell_q <= '0;
                                if (sw == MODE_FADE) begin
                                    state_q <= StFade;
                                end else begin
                                    idx_q <= nxt;
                                    wr_q  <= tgt_r;
                                    wg_q  <= tgt_g;
                                    wb_q  <= tgt_b;
                                end
                            end else begin
                                dwell_q <= dwell_q + DwW'(1);
                            end
                        end
                    end
                    StFade: begin
                        if (tick) begin
                            wr_q <= fr;
                            wg_q <= fg;
                            wb_q <= fb;
                            if (fade_done) begin
                                idx_q   <= nxt;
                                state_q <= StDwell;
                            end
                        end
                    end
                    StBlank: begin
                        wr_q <= '0;
                        wg_q <= '0;
                        wb_q <= '0;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Shadow registers: duty values only move on a PWM period boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_q <= '0;
            g_out_q <= '0;
            b_out_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            upd_q <= period_end;
            if (period_end) begin
                r_out_q <= wr_q;
                g_out_q <= wg_q;
                b_out_q <= wb_q;
            end
        end
    end

    assign R_time_out = r_out_q;
    assign G_time_out = g_out_q;
    assign B_time_out = b_out_q;
    assign color_idx  = idx_q;
    assign upd        = upd_q;

endmodule

// File: tb/tb_rgb_color_sequencer.sv
// Self-checking bench for rgb_color_sequencer (PRESCALE=4, DWELL=3).
module tb_rgb_color_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [1:0] sw  = 2'b00;
    logic       pe_gen;
    logic       pe_man = 1'b0;
    logic       pe_on  = 1'b0;
    logic       period_end;
    logic [7:0] r, g, b;
    logic [2:0] idx;
    logic       upd;

    int unsigned pe_cnt;
    int unsigned cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    assign period_end = pe_gen | pe_man;

    rgb_color_sequencer #(
        .PRESCALE(4),
        .DWELL   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sw        (sw),
        .period_end(period_end),
        .R_time_out(r),
        .G_time_out(g),
        .B_time_out(b),
        .color_idx (idx),
        .upd       (upd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) cyc <= cyc + 1;

    // period_end generator: one full-cycle pulse every 8 cycles.
    always @(negedge clk or negedge rst) begin
        if (!rst) begin
            pe_cnt <= 0;
            pe_gen <= 1'b0;
        end else if (pe_on) begin
            pe_cnt <= (pe_cnt == 7) ? 0 : pe_cnt + 1;
            pe_gen <= (pe_cnt == 6);
        end else begin
            pe_cnt <= 0;
            pe_gen <= 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] idx;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } vec_t;

    vec_t vt [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic check_rgb(input string name, input logic [7:0] er, input logic [7:0] eg,
                             input logic [7:0] eb);
        check({name, " R"}, 32'(r), 32'(er));
        check({name, " G"}, 32'(g), 32'(eg));
        check({name, " B"}, 32'(b), 32'(eb));
    endtask

    task automatic wait_idx(input logic [2:0] exp, input int budget);
        int w = 0;
        while (idx !== exp && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("color_idx reached", 32'(idx), 32'(exp));
    endtask

    // Skips the current cycle so the load seen reflects changes made up to now.
    task automatic wait_upd(input int budget);
        int w = 0;
        @(negedge clk);
        while (upd !== 1'b1 && w < budget) begin
            @(negedge clk);
            w++;
        end
        check("upd pulse seen", 32'(upd), 32'd1);
    endtask

    initial begin
        int t_prev;
        int viol;
        int waited;
        int prev_g;
        int fr;
        logic ok;

        vt[0] = '{3'd1, 8'd255, 8'd97,  8'd0};
        vt[1] = '{3'd2, 8'd255, 8'd255, 8'd0};
        vt[2] = '{3'd3, 8'd0,   8'd255, 8'd0};
        vt[3] = '{3'd4, 8'd0,   8'd0,   8'd255};
        vt[4] = '{3'd5, 8'd8,   8'd46,  8'd84};
        vt[5] = '{3'd6, 8'd160, 8'd32,  8'd240};
        vt[6] = '{3'd0, 8'd255, 8'd0,   8'd0};

        // 1. Reset and static mode
        en = 1'b1;
        pe_on = 1'b1;
        repeat (3) @(negedge clk);
        check_rgb("in reset", 8'd0, 8'd0, 8'd0);
        check("in reset idx", 32'(idx), 32'd0);
        check("in reset upd", 32'(upd), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_rgb("before first period_end", 8'd0, 8'd0, 8'd0);
        wait_upd(20);
        check_rgb("static red", 8'd255, 8'd0, 8'd0);
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (idx !== 3'd0 || r !== 8'd255 || g !== 8'd0 || b !== 8'd0) viol++;
        end
        check("static hold violations", 32'(viol), 32'd0);

        // 2. Step mode through the whole palette with wrap
        sw = 2'b01;
        t_prev = 0;
        for (int i = 0; i < 7; i++) begin
            wait_idx(vt[i].idx, 40);
            if (i > 0) check("step spacing", 32'(int'(cyc) - t_prev), 32'd12);
            t_prev = int'(cyc);
            wait_upd(12);
            check_rgb("step colour", vt[i].r, vt[i].g, vt[i].b);
        end

        // 3. Fade from idx 0 after reset: 12-cycle dwell + 97 ticks of 4 cycles
        @(negedge clk);
        rst = 1'b0;
        sw = 2'b10;
        @(negedge clk);
        rst = 1'b1;
        prev_g = 0;
        viol = 0;
        waited = 0;
        while (idx !== 3'd1 && waited < 600) begin
            @(negedge clk);
            waited++;
            if (upd === 1'b1) begin
                if (r !== 8'd255 || b !== 8'd0 || int'(g) < prev_g || int'(g) > prev_g + 2 ||
                    g > 8'd97) viol++;
                prev_g = int'(g);
            end
        end
        check("fade reached idx 1", 32'(idx), 32'd1);
        check("fade duration cycles", 32'(waited), 32'd400);
        check("fade ramp shape violations", 32'(viol), 32'd0);
        wait_upd(12);
        check_rgb("fade arrival orange", 8'd255, 8'd97, 8'd0);

        // 4. Shadow timing: working goes to 0 while period_end stays low
        #2 pe_on = 1'b0;
        sw = 2'b11;
        viol = 0;
        repeat (40) begin
            @(negedge clk);
            if (r !== 8'd255 || g !== 8'd97 || b !== 8'd0 || upd !== 1'b0) viol++;
        end
        check("shadow hold violations", 32'(viol), 32'd0);
        pe_man = 1'b1;
        check_rgb("before pulse edge", 8'd255, 8'd97, 8'd0);
        @(negedge clk);
        pe_man = 1'b0;
        check_rgb("after pulse edge", 8'd0, 8'd0, 8'd0);
        check("upd with load", 32'(upd), 32'd1);
        @(negedge clk);
        check("upd one cycle only", 32'(upd), 32'd0);

        // 5. Fade from blank, freeze, resume, blank, fade again
        #2 pe_on = 1'b1;
        sw = 2'b10;
        repeat (100) @(negedge clk);
        wait_upd(12);
        ok = (r == g) && (b == 8'd0) && (r >= 8'd24) && (r <= 8'd28);
        check("fade from blank in range", 32'(ok), 32'd1);
        #2 en = 1'b0;
        repeat (10) @(negedge clk);
        fr = int'(r);
        viol = 0;
        repeat (50) begin
            @(negedge clk);
            if (int'(r) != fr || int'(g) != fr || b !== 8'd0 || idx !== 3'd1) viol++;
        end
        check("freeze violations", 32'(viol), 32'd0);
        check("freeze idx", 32'(idx), 32'd1);
        #2 en = 1'b1;
        repeat (40) @(negedge clk);
        wait_upd(12);
        ok = (int'(r) > fr) && (int'(r) <= fr + 13) && (r == g);
        check("resume continues ramp", 32'(ok), 32'd1);
        sw = 2'b11;
        repeat (20) @(negedge clk);
        wait_upd(12);
        check_rgb("blank mid-fade", 8'd0, 8'd0, 8'd0);
        check("blank keeps idx", 32'(idx), 32'd1);
        sw = 2'b10;
        repeat (20) @(negedge clk);
        wait_upd(12);
        ok = (r == g) && (b == 8'd0) && (r >= 8'd1) && (r <= 8'd8);
        check("refade from zero", 32'(ok), 32'd1);

        // 6. Asynchronous reset between clock edges
        repeat (30) @(negedge clk);
        check("pre-reset nonzero", 32'(r != 8'd0), 32'd1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_rgb("async reset", 8'd0, 8'd0, 8'd0);
        check("async reset idx", 32'(idx), 32'd0);
        check("async reset upd", 32'(upd), 32'd0);
        @(negedge clk);
        sw = 2'b00;
        rst = 1'b1;
        wait_upd(20);
        check_rgb("restart red", 8'd255, 8'd0, 8'd0);
        check("restart idx", 32'(idx), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
